// File: rtl/contadores_reader_pkg.sv
// contadores_reader_pkg: shared defaults and FSM encoding for the counter reader
package contadores_reader_pkg;
  localparam int DEF_N_CNT = 5;
  localparam int DEF_W = 5;
  localparam int DEF_IDX_W = 3;
  localparam logic [DEF_IDX_W-1:0] DEF_IDLE_IDX = 3'b111;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/contadores_reader_if.sv
// contadores_reader_if: request, counter-block link and result bank of the reader
interface contadores_reader_if #(
  parameter int W = 5,
  parameter int IDX_W = 3
);
  logic             req;
  logic             valid_in;
  logic [W-1:0]     data_in;
  logic [IDX_W-1:0] idx;
  logic             busy;
  logic             done;
  logic [W-1:0]     cnt_0, cnt_1, cnt_2, cnt_3, cnt_4;
  logic [W+2:0]     sum;
  modport master (
    output req, valid_in, data_in,
    input  idx, busy, done, cnt_0, cnt_1, cnt_2, cnt_3, cnt_4, sum
  );
  modport slave (
    input  req, valid_in, data_in,
    output idx, busy, done, cnt_0, cnt_1, cnt_2, cnt_3, cnt_4, sum
  );
endinterface

// File: rtl/contadores_reader_sum.sv
// contadores_reader_sum: combinational adder tree over the result bank
module contadores_reader_sum #(
  parameter int N = 5,
  parameter int W = 5
) (
  input  logic [W-1:0] i_term [N],
  output logic [W+2:0] o_sum
);
  always_comb begin
    o_sum = '0;
    for (int k = 0; k < N; k++) o_sum = o_sum + (W+3)'(i_term[k]);
  end
endmodule

// File: rtl/contadores_reader.sv
// contadores_reader: sweeps the pop-counter select, captures all counters and
// publishes them with their total in one atomic update.
module contadores_reader
  import contadores_reader_pkg::*;
#(
  parameter int N_CNT = DEF_N_CNT,
  parameter int W = DEF_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter logic [IDX_W-1:0] IDLE_IDX = DEF_IDLE_IDX
) (
  input logic clk,
  input logic reset_L,
  contadores_reader_if.slave bus
);
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy, r_done;
  logic [W-1:0]     r_stage [N_CNT];
  logic [W-1:0]     r_cnt [N_CNT];
  logic [W+2:0]     r_sum;
  logic [W-1:0]     w_bank [N_CNT];
  logic [W+2:0]     w_sum;
  logic             w_start, w_last;
  assign w_start = bus.req & bus.valid_in;
  assign w_last = r_idx == IDX_W'(N_CNT-1);
  // the last counter arrives on the same edge the bank is published
  always_comb begin
    w_bank = r_stage;
    w_bank[N_CNT-1] = bus.data_in;
  end
  contadores_reader_sum #(.N(N_CNT), .W(W)) u_sum (.i_term(w_bank), .o_sum(w_sum));
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      r_state <= IDLE;
      r_idx <= IDLE_IDX;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sum <= '0;
      for (int k = 0; k < N_CNT; k++) begin
        r_stage[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SWEEP, DRAIN:
          if (!bus.valid_in) begin
            r_state <= IDLE;
            r_idx <= IDLE_IDX;
            r_busy <= 1'b0;
          end else if (r_state == SWEEP) begin
            if (r_idx != '0) r_stage[r_idx - IDX_W'(1)] <= bus.data_in;
            r_idx <= w_last ? IDLE_IDX : r_idx + IDX_W'(1);
            r_state <= w_last ? DRAIN : SWEEP;
          end else begin
            r_stage[N_CNT-1] <= bus.data_in;
            r_cnt <= w_bank;
            r_sum <= w_sum;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_state <= DONE;
          end
        default: begin
          r_state <= w_start ? SWEEP : IDLE;
          r_idx <= w_start ? '0 : IDLE_IDX;
          r_busy <= w_start;
        end
      endcase
    end
  assign bus.idx = r_idx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum = r_sum;
  assign bus.cnt_0 = r_cnt[0];
  assign bus.cnt_1 = r_cnt[1];
  assign bus.cnt_2 = r_cnt[2];
  assign bus.cnt_3 = r_cnt[3];
  assign bus.cnt_4 = r_cnt[4];
endmodule

// File: tb/tb_contadores_reader.sv
// tb_contadores_reader: directed bench with a behavioural pop-counter block
module tb_contadores_reader;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;
  contadores_reader_if #(.W(5), .IDX_W(3)) bus ();
  contadores_reader dut (.clk(clk), .reset_L(reset_L), .bus(bus));
  // pop-counter model: registered data_out that holds when the selected counter is zero
  logic       c_rst_n = 1'b0;
  logic       ld = 1'b0;
  logic       pop4 = 1'b0;
  logic [4:0] c [5];
  logic [4:0] ld_val [5];
  logic [4:0] dout;
  logic [4:0] sel;
  always_comb sel = (bus.idx < 3'd5) ? c[bus.idx] : 5'd0;
  always @(posedge clk)
    if (!c_rst_n) begin
      for (int i = 0; i < 5; i++) c[i] <= 5'd0;
      dout <= 5'd0;
    end else begin
      if (ld) c <= ld_val;
      else if (pop4) c[4] <= c[4] + 5'd1;
      if (sel != 5'd0) dout <= sel;
    end
  assign bus.valid_in = c_rst_n;
  assign bus.data_in = dout;
  int errors = 0;
  int checks = 0;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_bank(input string tag, input int e0, e1, e2, e3, e4, es);
    chk({tag, "_cnt0"}, bus.cnt_0, e0);
    chk({tag, "_cnt1"}, bus.cnt_1, e1);
    chk({tag, "_cnt2"}, bus.cnt_2, e2);
    chk({tag, "_cnt3"}, bus.cnt_3, e3);
    chk({tag, "_cnt4"}, bus.cnt_4, e4);
    chk({tag, "_sum"}, bus.sum, es);
  endtask
  task automatic preload(input int a, b, d, e, f);
    ld_val[0] = 5'(a); ld_val[1] = 5'(b); ld_val[2] = 5'(d);
    ld_val[3] = 5'(e); ld_val[4] = 5'(f);
    ld = 1'b1;
    step();
    ld = 1'b0;
  endtask
  // full sweep from accept to the cycle after done; optional req pulse while busy
  task automatic sweep(input string tag, input bit pop, input bit mid_req,
                       input int e0, e1, e2, e3, e4, es);
    bus.req = 1'b1;
    step();
    pop4 = pop;
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_idx"}, bus.idx, k);
      chk({tag, "_busy"}, bus.busy, 1);
      bus.req = mid_req && k == 2;
      step();
    end
    chk({tag, "_drain_busy"}, bus.busy, 1);
    chk({tag, "_drain_done"}, bus.done, 0);
    step();
    pop4 = 1'b0;
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_done_busy"}, bus.busy, 0);
    chk_bank(tag, e0, e1, e2, e3, e4, es);
    step();
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_idle_idx"}, bus.idx, 7);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask
  initial begin
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    c_rst_n = 1'b1;
    step();
    step();
    chk("rst_idx", bus.idx, 7);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk_bank("rst", 0, 0, 0, 0, 0, 0);
    preload(3, 0, 7, 1, 31);
    sweep("basic", 1'b0, 1'b1, 3, 3, 7, 1, 31, 45);
    preload(3, 0, 7, 1, 10);
    sweep("pops", 1'b1, 1'b0, 3, 3, 7, 1, 14, 28);
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    step();
    step();
    c_rst_n = 1'b0;
    step();
    chk("abort_busy", bus.busy, 0);
    chk("abort_idx", bus.idx, 7);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", bus.done, 0);
      step();
    end
    chk_bank("abort", 3, 3, 7, 1, 14, 28);
    bus.req = 1'b1;
    step();
    chk("noval_req_busy", bus.busy, 0);
    chk("noval_req_idx", bus.idx, 7);
    bus.req = 1'b0;
    c_rst_n = 1'b1;
    step();
    preload(2, 4, 6, 8, 10);
    bus.req = 1'b1;
    repeat (7) step();
    chk("b2b_done", bus.done, 1);
    chk_bank("b2b", 2, 4, 6, 8, 10, 30);
    step();
    chk("b2b_idx0", bus.idx, 0);
    chk("b2b_busy", bus.busy, 1);
    bus.req = 1'b0;
    begin
      int n = 0;
      while (!bus.done && n < 20) begin
        step();
        n++;
      end
      chk("b2b_second_done", bus.done, 1);
      chk("b2b_second_sum", bus.sum, 30);
    end
    step();
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    repeat (3) step();
    chk("arst_pre_busy", bus.busy, 1);
    reset_L = 1'b0;
    #1;
    chk("arst_idx", bus.idx, 7);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk_bank("arst", 0, 0, 0, 0, 0, 0);
    step();
    reset_L = 1'b1;
    step();
    chk("arst_release_idx", bus.idx, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/contadores_reader.md
# contadores_reader

Sweeps the `idx` select port of the pop-counter block, captures every counter value into a parallel result bank, and reports a running total. It sits between the pop-counter block and the verification/report logic. A single request reads all counters in a pipelined sweep, one index per cycle. The pop-counter block's `data_out` is registered, and it holds its previous value when the selected counter is zero. This block reproduces that value as-is and does not reinterpret it.

## Interface
Parameters:
- `N_CNT`, default 5: number of counters swept (indices 0..N_CNT-1).
- `W`, default 5: counter width.
- `IDX_W`, default 3: select width.
- `IDLE_IDX`, default 3'b111: index driven when not sweeping; it selects no counter.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset_L` in 1: asynchronous, active-low reset.
- `req` in 1: sweep request, single-cycle pulse or level.
- `valid_in` in 1: `valid` from the counter block.
- `data_in` in W: `data_out` from the counter block.
- `idx` out IDX_W: select driven to the counter block (registered).
- `busy` out 1: high from request acceptance until `done`.
- `done` out 1: one-cycle pulse when the result bank is updated.
- `cnt_0` … `cnt_4` out W each: captured counter values.
- `sum` out W+3: sum of `cnt_0..cnt_4`, zero-extended, no overflow possible.

## Operation
- **Reset (async, `reset_L`=0):**
  - State=IDLE.
  - `idx`=IDLE_IDX.
  - `busy`=0, `done`=0.
  - All `cnt_k`=0, `sum`=0.
- **FSM states:** IDLE, SWEEP, DRAIN, DONE.
- **IDLE:** `idx`=IDLE_IDX. On `req`=1 and `valid_in`=1, go to SWEEP. In that case `idx`←0, `k`←0 and `busy`←1. A `req` while `valid_in`=0 is ignored (dropped, not queued).
- **SWEEP:** each cycle `idx`←`idx`+1. Capture `data_in` into staging slot `idx`−1 for every cycle after the first. After `idx`=N_CNT−1 is driven, go to DRAIN.
- **DRAIN:** capture `data_in` into slot N_CNT−1. `idx`←IDLE_IDX. Go to DONE.
- **DONE:**
  - Copy the staging bank to `cnt_k` and compute `sum`.
  - Pulse `done`=1.
  - `busy`←0.
  - Go to IDLE.
- **Staging bank:** `cnt_k` outputs change only in DONE. A partially swept set is never visible.
- **`req` while `busy`:** ignored. A `req` held high starts a new sweep in the cycle after DONE; that is back-to-back operation.
- **`valid_in` falls during SWEEP or DRAIN** (counter block reset):
  - Abort, return to IDLE and set `idx`=IDLE_IDX.
  - `busy`←0, no `done`.
  - `cnt_k` and `sum` keep their previous values.
- **Arithmetic:** `sum` = Σ `cnt_k`. Each term is zero-extended to W+3 bits, so the maximum 5×31=155 fits in 8 bits.

## Timing
- **Capture alignment:** `idx`=k is driven in cycle t. The counter block registers it at edge t+1. The reader samples `data_in` at edge t+2 as the value for k.
- **Sweep latency:** the `req` accept edge is cycle 0.
  - `idx`=0..4 in cycles 1..5.
  - DRAIN in cycle 6.
  - `done` and new `cnt_k`/`sum` visible in cycle 7.
  - Total 7 cycles, then IDLE in cycle 8.
- **Pop during a sweep:** the captured value for counter k reflects pops up to 2 cycles before its capture edge. No snapshot consistency across counters is guaranteed.
- **`done` and `busy`:** `done` is high exactly one cycle. `busy` is high in cycles 1..6 and low in the `done` cycle.
- **Reset mid-sweep:** all outputs immediately return to their reset values, with no clock required.

## Structure
- Shared package:
  - State encoding constants (IDLE=2'd0, SWEEP=2'd1, DRAIN=2'd2, DONE=2'd3).
  - `IDLE_IDX`.
  - Default `N_CNT`, `W` and `IDX_W`, so the counter block and the reader agree.
- One natural sub-module is `contadores_reader_sum`: a combinational adder tree over the staging bank, whose result is registered in DONE.
- The FSM, staging bank and output registers stay in the top module.

## Test plan
- **Reset then idle:** `reset_L`=0 for 2 cycles, release, no `req` → `idx`=3'b111, `busy`=0, all `cnt_k`=0, `sum`=0.
- **Basic sweep:**
  - Stimulus: pop counts 3,0,7,1,31 preloaded. Counter 1 is zero, so `data_out` holds 3. Then `req` pulse.
  - Required response: `idx` sequence 0,1,2,3,4 in cycles 1..5; `done` in cycle 7; `cnt`=3,3,7,1,31; `sum`=45.
- **Pops during sweep:** `pop_4` held high through the sweep from `data_4`=10 → `cnt_4`=14, one increment per cycle up to capture.
- **Abort:** the counter block's `reset_L` is dropped in cycle 3 of a sweep → `busy` falls, no `done`, `cnt_k` unchanged from the previous sweep.
- **Request handling:** `req` pulsed while `busy` → ignored. `req` held high → second sweep `idx`=0 in the cycle after `done`.
- **Async reset mid-sweep:** `reset_L`=0 between clock edges in cycle 4 → outputs return to reset values before the next edge.
